// File: rtl/qclk_pkg.sv
`default_nettype none
// ============================================================================
// Module : qclk_pkg
// Brief  : State encoding and default widths shared by the quadrature
//          clock burst generator.
// Rev    : 1.0
// ============================================================================
package qclk_pkg;

  typedef enum logic [0:0] {
    QCLK_IDLE = 1'b0,
    QCLK_RUN  = 1'b1
  } qclk_state_e;

  localparam int DIV_W_DEF = 8;
  localparam int CNT_W_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/quadrature_clock_burst_gen.sv
`default_nettype none
// ============================================================================
// Module : quadrature_clock_burst_gen
// Brief  : 0/90 degree clock pair at period 4*div_q with counted or
//          free-running bursts, graceful stop and per-edge strobes.
// Rev    : 1.0
// ============================================================================
module quadrature_clock_burst_gen
  import qclk_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             free_run,
  input  logic [DIV_W-1:0] div_q,
  input  logic [CNT_W-1:0] n_cycles,
  input  logic             cpol,
  output logic             sck_0,
  output logic             sck_90,
  output logic             sck_0_lead,
  output logic             sck_0_trail,
  output logic             sck_90_lead,
  output logic             sck_90_trail,
  output logic             busy,
  output logic             done
);

  localparam int CW = DIV_W + 2;

  qclk_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    dq_q, dq_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             pol_q, pol_d;
  logic             fr_q, fr_d;
  logic             stop_pend_q, stop_pend_d;
  logic             end_run;

  logic [CW-1:0]    last_cnt;
  logic [CW-1:0]    two_d, three_d;
  logic             run_d;

  logic sck_0_q, sck_0_d, sck_90_q, sck_90_d;
  logic lead0_q, lead0_d, trail0_q, trail0_d;
  logic lead90_q, lead90_d, trail90_q, trail90_d;
  logic done_q;

  assign last_cnt = (dq_q << 2) - CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dq_d        = dq_q;
    left_d      = left_q;
    pol_d       = pol_q;
    fr_d        = fr_q;
    stop_pend_d = stop_pend_q;
    end_run     = 1'b0;

    case (state_q)
      QCLK_IDLE: begin
        if (start) begin
          // A zero-length counted burst completes without producing any edge.
          if (!free_run && (n_cycles == '0)) begin
            end_run = 1'b1;
          end else begin
            state_d     = QCLK_RUN;
            cnt_d       = '0;
            dq_d        = (div_q == '0) ? CW'(1) : CW'(div_q);
            pol_d       = cpol;
            fr_d        = free_run;
            left_d      = n_cycles;
            stop_pend_d = 1'b0;
          end
        end
      end

      QCLK_RUN: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (cnt_q == last_cnt) begin
          if ((!fr_q && (left_q == CNT_W'(1))) || stop || stop_pend_q) begin
            state_d     = QCLK_IDLE;
            cnt_d       = '0;
            stop_pend_d = 1'b0;
            end_run     = 1'b1;
          end else begin
            cnt_d = '0;
            if (!fr_q) begin
              left_d = left_q - CNT_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = QCLK_IDLE;
      end
    endcase
  end

  // Outputs are decoded from next-state values so the registers line up with cnt_q.
  always_comb begin
    run_d     = (state_d == QCLK_RUN);
    two_d     = dq_d << 1;
    three_d   = two_d + dq_d;
    sck_0_d   = run_d ? (pol_d ^ (cnt_d < two_d)) : cpol;
    sck_90_d  = run_d ? (pol_d ^ ((cnt_d >= dq_d) && (cnt_d < three_d))) : cpol;
    lead0_d   = run_d && (cnt_d == '0);
    trail0_d  = run_d && (cnt_d == two_d);
    lead90_d  = run_d && (cnt_d == dq_d);
    trail90_d = run_d && (cnt_d == three_d);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= QCLK_IDLE;
      cnt_q       <= '0;
      dq_q        <= '0;
      left_q      <= '0;
      pol_q       <= 1'b0;
      fr_q        <= 1'b0;
      stop_pend_q <= 1'b0;
      sck_0_q     <= 1'b0;
      sck_90_q    <= 1'b0;
      lead0_q     <= 1'b0;
      trail0_q    <= 1'b0;
      lead90_q    <= 1'b0;
      trail90_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dq_q        <= dq_d;
      left_q      <= left_d;
      pol_q       <= pol_d;
      fr_q        <= fr_d;
      stop_pend_q <= stop_pend_d;
      sck_0_q     <= sck_0_d;
      sck_90_q    <= sck_90_d;
      lead0_q     <= lead0_d;
      trail0_q    <= trail0_d;
      lead90_q    <= lead90_d;
      trail90_q   <= trail90_d;
      done_q      <= end_run;
    end
  end

  assign sck_0        = sck_0_q;
  assign sck_90       = sck_90_q;
  assign sck_0_lead   = lead0_q;
  assign sck_0_trail  = trail0_q;
  assign sck_90_lead  = lead90_q;
  assign sck_90_trail = trail90_q;
  assign busy         = (state_q == QCLK_RUN);
  assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_quadrature_clock_burst_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_quadrature_clock_burst_gen
// Brief  : Scoreboard bench; per-cycle expected outputs of each run are
//          queued from a behavioural model and popped by a monitor.
// Rev    : 1.0
// ============================================================================
module tb_quadrature_clock_burst_gen;

  localparam int DIV_W = 8;
  localparam int CNT_W = 16;

  logic             clk_in = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic             free_run;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] n_cycles;
  logic             cpol;
  logic             sck_0, sck_90, sck_0_lead, sck_0_trail;
  logic             sck_90_lead, sck_90_trail, busy, done;

  // {busy, done, sck_0, sck_90, sck_0_lead, sck_0_trail, sck_90_lead, sck_90_trail}
  typedef logic [7:0] vec_t;
  vec_t exp_q[$];
  vec_t mon_e;
  int   tests = 0;
  int   fails = 0;

  quadrature_clock_burst_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .free_run     (free_run),
    .div_q        (div_q),
    .n_cycles     (n_cycles),
    .cpol         (cpol),
    .sck_0        (sck_0),
    .sck_90       (sck_90),
    .sck_0_lead   (sck_0_lead),
    .sck_0_trail  (sck_0_trail),
    .sck_90_lead  (sck_90_lead),
    .sck_90_trail (sck_90_trail),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk_in = ~clk_in;

  function automatic vec_t obs();
    return {busy, done, sck_0, sck_90, sck_0_lead, sck_0_trail, sck_90_lead, sck_90_trail};
  endfunction

  always @(negedge clk_in) begin
    if (!reset && (busy || done)) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL spurious_output t=%0t got %b expected nothing", $time, obs());
      end else begin
        mon_e = exp_q.pop_front();
        if (obs() !== mon_e) begin
          fails++;
          $display("FAIL scoreboard t=%0t got %b expected %b", $time, obs(), mon_e);
        end
      end
    end
  end

  // Model: every period is 4*dq cycles; each clock is active for a half period,
  // sck_90 offset by a quarter; one done cycle at the idle level follows.
  task automatic push_run(input int dq, input int periods, input bit pol);
    bit s0, s90;
    for (int p = 0; p < periods; p++) begin
      for (int c = 0; c < 4 * dq; c++) begin
        s0  = pol ^ (c < 2 * dq);
        s90 = pol ^ ((c >= dq) && (c < 3 * dq));
        exp_q.push_back({1'b1, 1'b0, s0, s90, c == 0, c == 2 * dq, c == dq, c == 3 * dq});
      end
    end
    exp_q.push_back({1'b0, 1'b1, pol, pol, 4'b0000});
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %b expected %b", name, got, want);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) begin
      tests++;
      fails++;
      $display("FAIL timeout got %0d pending entries expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // stop_at < 0: no stop; otherwise stop is high during run cycle stop_at.
  task automatic run(input int dq, input int n, input bit fr, input bit pol,
                     input int stop_at, input bit stop_with_start);
    int dq_e, p_len, periods;
    dq_e  = (dq == 0) ? 1 : dq;
    p_len = 4 * dq_e;
    if (!fr && n == 0) begin
      periods = 0;
    end else if (fr) begin
      periods = stop_at / p_len + 1;
    end else begin
      periods = n;
      if (stop_at >= 0 && (stop_at / p_len + 1) < n) periods = stop_at / p_len + 1;
    end
    push_run(dq_e, periods, pol);
    div_q    = DIV_W'(dq);
    n_cycles = CNT_W'(n);
    free_run = fr;
    cpol     = pol;
    start    = 1'b1;
    stop     = stop_with_start;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    if (stop_at >= 0) begin
      repeat (stop_at) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    wait_drain();
    repeat (2) tick();
    check("idle_level", {busy, done, sck_0, sck_90, 4'b0000}, {2'b00, pol, pol, 4'b0000});
  endtask

  initial begin
    int dq, n, p_len, stop_at;
    bit fr, pol;
    reset = 1'b1; start = 1'b0; stop = 1'b0; free_run = 1'b0;
    div_q = '0; n_cycles = '0; cpol = 1'b1;
    #1;
    check("reset_state", obs(), 8'h00);
    repeat (3) tick();
    check("reset_held_state", obs(), 8'h00);
    reset = 1'b0;
    cpol  = 1'b0;
    tick();

    run(1, 3, 1'b0, 1'b0, -1, 1'b0);       // 1: dq=1, n=3
    run(0, 1, 1'b0, 1'b0, -1, 1'b0);       // 2: div_q=0 behaves as 1
    run(2, 2, 1'b0, 1'b1, -1, 1'b0);       // 3: cpol=1, dq=2
    run(3, 0, 1'b1, 1'b0, 17, 1'b0);       // 4: free run, stop at cnt 5 of 2nd period
    run(2, 0, 1'b0, 1'b1, -1, 1'b0);       // zero-length burst: done only
    run(2, 3, 1'b0, 1'b0, -1, 1'b1);       // start+stop together: stop discarded
    run(1, 4, 1'b0, 1'b1, 5, 1'b0);        // stop in counted burst ends at boundary

    // Stop while idle must not leave a pending stop behind.
    stop = 1'b1; tick(); stop = 1'b0; tick();
    run(1, 2, 1'b0, 1'b0, -1, 1'b0);

    // 5: div_q/cpol changes and a re-start mid-burst are ignored.
    push_run(2, 4, 1'b0);
    div_q = 8'd2; n_cycles = 16'd4; free_run = 1'b0; cpol = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    div_q = 8'd5; cpol = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    cpol = 1'b0;
    wait_drain();
    repeat (2) tick();

    // 6: reset at cnt=2 of the second period.
    div_q = 8'd1; n_cycles = 16'd3; free_run = 1'b0; cpol = 1'b0; start = 1'b1;
    push_run(1, 3, 1'b0);
    tick();
    start = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    #1;
    check("reset_mid_run", obs(), 8'h00);
    exp_q.delete();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    run(1, 1, 1'b0, 1'b0, -1, 1'b0);

    for (int i = 0; i < 25; i++) begin
      dq    = int'($urandom_range(0, 4));
      n     = int'($urandom_range(0, 4));
      fr    = ($urandom_range(0, 3) == 0);
      pol   = $urandom_range(0, 1) == 1;
      p_len = 4 * ((dq == 0) ? 1 : dq);
      if (fr) stop_at = int'($urandom_range(0, 3 * p_len - 1));
      else if ($urandom_range(0, 2) == 0) stop_at = int'($urandom_range(0, n * p_len + 3));
      else stop_at = -1;
      run(dq, n, fr, pol, stop_at, 1'b0);
    end

    repeat (4) tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_entries got %0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/quadrature_clock_burst_gen.md
Name: quadrature_clock_burst_gen

Overview:
Parametrised successor to the fixed 8-bit quadrature divider. It generates a 0° / 90° clock pair from the fast clk_in at period 4*div_q, with selectable idle polarity and a start/stop handshake. It runs either a counted burst of N periods or free-runs until stopped. Per-edge strobes let SPI shifters sample and launch without re-detecting edges. It sits between the AXI register block and the bidirectional SPI shift engine.

Parameters:
DIV_W, 8, width of div_q (counts per quarter cycle); counter width is DIV_W+2.
CNT_W, 16, width of n_cycles (burst length in full periods).

Ports:
clk_in  input  1  fast input clock
reset  input  1  asynchronous, active-high reset
start  input  1  request a burst or run; accepted only in IDLE
stop  input  1  graceful stop request; honoured only in RUN
free_run  input  1  sampled at accept; 1 = ignore n_cycles and run until stop
div_q  input  DIV_W  counts per quarter cycle; 0 is treated as 1
n_cycles  input  CNT_W  burst length in periods
cpol  input  1  idle level of both clocks
sck_0  output  1  0° clock
sck_90  output  1  90° clock
sck_0_lead  output  1  1-cycle pulse: sck_0 leaves idle level
sck_0_trail  output  1  1-cycle pulse: sck_0 returns to idle level
sck_90_lead  output  1  1-cycle pulse: sck_90 leaves idle level
sck_90_trail  output  1  1-cycle pulse: sck_90 returns to idle level
busy  output  1  high while in RUN
done  output  1  1-cycle pulse when a run ends normally

Behaviour:
- Reset (async, immediate): state IDLE, cnt=0, all outputs 0, cpol_q=0.
- States: IDLE and RUN only.
- IDLE:
  - sck_0 = sck_90 = cpol_q, where cpol_q is cpol registered every cycle (1 cycle delay); busy=0.
  - start=1 with free_run=0 and n_cycles=0: stay IDLE; done pulses the next cycle; no clock edges.
  - start=1 otherwise (accept at edge k):
    - latch dq = max(div_q,1), pol = cpol, fr = free_run, left = n_cycles; cnt <= 0; enter RUN.
    - From cycle k+1: busy=1, sck_0 active (= ~pol), sck_0_lead=1.
- RUN:
  - cnt runs 0..P-1 with P = 4*dq; all arithmetic is DIV_W+2 bits wide, no overflow.
  - Registered outputs stay consistent with the cnt register:
    - sck_0 active iff cnt < 2dq.
    - sck_90 active iff dq <= cnt < 3dq.
  - Strobes are high in the first cycle an output shows its new level: lead at cnt==0 (sck_0) and cnt==dq (sck_90); trail at cnt==2dq and cnt==3dq.
  - div_q and cpol changes are ignored until the next accept.
  - Period boundary (cnt==P-1): the run ends if (fr==0 and left==1) or a stop is pending (stop seen this cycle or earlier in the run). Otherwise cnt <= 0 and left decrements when fr==0.
  - On end: next cycle state IDLE, busy=0, done=1 for 1 cycle. Both clocks are already at idle level, so no glitch.
- Stop: latched as pending; the current period always completes and the run never truncates mid-period. Stop in IDLE is ignored.
- start during RUN is ignored.
- start and stop asserted together in IDLE: start is accepted and stop is discarded.
- Burst occupancy: busy is high for exactly n_cycles*P cycles.
- Reset mid-run: immediate return to reset values; no done pulse.

Decomposition:
- Package qclk_pkg holds the state enum (QCLK_IDLE, QCLK_RUN) and the constants DIV_W_DEF=8 and CNT_W_DEF=16.
- Single module; no sub-module is warranted, because the counter, phase compare and strobes share the same cnt register.

Test Plan:
1. DIV_W=8, dq=1, n=3, cpol=0, start pulse -> busy high 12 cycles; sck_0 = 1100 x3, sck_90 = 0110 x3; 3 of each strobe; done 1 cycle as busy falls.
2. div_q=0, n=1 -> behaves as dq=1: period 4, busy 4 cycles, one done.
3. cpol=1, dq=2, n=2 -> idle high; sck_0 low cnt 0-3 and high 4-7; sck_90 low cnt 2-5; busy 16 cycles.
4. free_run=1, dq=3, stop pulsed at cnt=5 of period 2 -> period completes to cnt=11, then IDLE; busy 24 cycles total; done pulses.
5. dq=2, n=4, div_q changed to 5 and start re-pulsed mid-burst -> period stays 8, busy 32 cycles, no restart.
6. Reset asserted at cnt=2 of period 1 -> outputs and busy 0 immediately, no done; a subsequent start with dq=1, n=1 runs normally.
